// File: rtl/im_boot_ctrl.sv
// Boot loader / access controller for the instruction memory: loads a length-prefixed
// image from the UART byte stream, then releases the CPU. Optional macro: BOOT_CHECKSUM_EN.
module im_boot_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_en,
    input  logic              boot_req,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_clr,
    input  logic [ADDR_W-1:0] cpu_fetch_addr,
    input  logic              cpu_rd_en,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_rd_en,
    output logic              im_we,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              err
);

    localparam int LEN_W = 12;
    localparam int CNT_W = ADDR_W + 1;
    localparam int CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;
    localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DAT_HI = 3'd3,
        S_DAT_LO = 3'd4,
        S_RUN    = 3'd5,
        S_ERR    = 3'd6
`ifdef BOOT_CHECKSUM_EN
        , S_CHK  = 3'd7
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    w_len_next;
    logic [CNT_W-1:0]    r_wcnt;
    logic [CNT_W-1:0]    w_wcnt_next;
    logic [7:0]          r_hi;
    logic [7:0]          w_hi_next;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   w_waddr_next;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_wdata_next;
    logic                r_rx_clr;
    logic                w_rx_clr_next;
    logic                r_im_we;
    logic                w_im_we_next;
    logic                r_cpu_rst_n;
    logic                w_cpu_rst_n_next;
    logic                r_busy;
    logic                w_busy_next;
    logic                r_err;
    logic                w_err_next;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]          r_chk;
    logic [7:0]          w_chk_next;
`endif

    logic                w_rx_state;
    logic                w_accept;
    logic [LEN_W-1:0]    w_len_rx;
    logic [CNT_W-1:0]    w_wcnt_inc;
    logic                w_pass;
    state_t              w_done_state;

`ifdef BOOT_CHECKSUM_EN
    assign w_done_state = S_CHK;
`else
    assign w_done_state = S_RUN;
`endif

    always_comb begin
        w_rx_state = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                     (r_state == S_DAT_HI) || (r_state == S_DAT_LO);
`ifdef BOOT_CHECKSUM_EN
        if (r_state == S_CHK) begin
            w_rx_state = 1'b1;
        end
`endif
    end

    // Holding off while rx_clr is still high keeps one byte from being taken twice.
    assign w_accept   = rx_rdy && !r_rx_clr && w_rx_state;
    assign w_len_rx   = {r_hi[3:0], rx_data};
    assign w_wcnt_inc = r_wcnt + 1'b1;

    always_comb begin
        w_state_next  = r_state;
        w_len_next    = r_len;
        w_wcnt_next   = r_wcnt;
        w_hi_next     = r_hi;
        w_waddr_next  = r_waddr;
        w_wdata_next  = r_wdata;
        w_rx_clr_next = w_accept;
        w_im_we_next  = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        w_chk_next    = r_chk;
        if (w_accept && (r_state != S_CHK)) begin
            w_chk_next = r_chk ^ rx_data;
        end
`endif
        case (r_state)
            S_IDLE: begin
                w_state_next = boot_en ? S_LEN_HI : S_RUN;
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    w_hi_next    = rx_data;
                    w_state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    w_len_next = w_len_rx;
                    if (w_len_rx == '0) begin
                        w_state_next = w_done_state;
                    end else if (CMP_W'(w_len_rx) > MAX_WORDS) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_wcnt_next  = '0;
                        w_state_next = S_DAT_HI;
                    end
                end
            end
            S_DAT_HI: begin
                if (w_accept) begin
                    w_hi_next    = rx_data;
                    w_state_next = S_DAT_LO;
                end
            end
            S_DAT_LO: begin
                if (w_accept) begin
                    w_im_we_next = 1'b1;
                    w_waddr_next = r_wcnt[ADDR_W-1:0];
                    w_wdata_next = DATA_W'({r_hi, rx_data});
                    w_wcnt_next  = w_wcnt_inc;
                    if (CMP_W'(w_wcnt_inc) == CMP_W'(r_len)) begin
                        w_state_next = w_done_state;
                    end else begin
                        w_state_next = S_DAT_HI;
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHK: begin
                if (w_accept) begin
                    w_state_next = (rx_data == r_chk) ? S_RUN : S_ERR;
                end
            end
`endif
            S_RUN, S_ERR: begin
                if (boot_req) begin
                    w_state_next = S_LEN_HI;
`ifdef BOOT_CHECKSUM_EN
                    w_chk_next   = '0;
`endif
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_busy_next = (w_state_next == S_LEN_HI) || (w_state_next == S_LEN_LO) ||
                      (w_state_next == S_DAT_HI) || (w_state_next == S_DAT_LO);
`ifdef BOOT_CHECKSUM_EN
        if (w_state_next == S_CHK) begin
            w_busy_next = 1'b1;
        end
`endif
        w_err_next       = (w_state_next == S_ERR);
        w_cpu_rst_n_next = (r_state == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_wcnt      <= '0;
            r_hi        <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_rx_clr    <= 1'b0;
            r_im_we     <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_chk       <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_len       <= w_len_next;
            r_wcnt      <= w_wcnt_next;
            r_hi        <= w_hi_next;
            r_waddr     <= w_waddr_next;
            r_wdata     <= w_wdata_next;
            r_rx_clr    <= w_rx_clr_next;
            r_im_we     <= w_im_we_next;
            r_cpu_rst_n <= w_cpu_rst_n_next;
            r_busy      <= w_busy_next;
            r_err       <= w_err_next;
`ifdef BOOT_CHECKSUM_EN
            r_chk       <= w_chk_next;
`endif
        end
    end

    // The final image word is written in the first RUN cycle, so the write address
    // keeps the port until that write completes; the CPU is still in reset then.
    assign w_pass    = (r_state == S_RUN) && !r_im_we;
    assign im_addr   = w_pass ? cpu_fetch_addr : r_waddr;
    assign im_rd_en  = w_pass && cpu_rd_en;
    assign im_we     = r_im_we;
    assign im_wdata  = r_wdata;
    assign rx_clr    = r_rx_clr;
    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
